// File: rtl/seven_seg_display.sv
// Score accumulator with a 4-digit BCD score and a multiplexed common-anode seven-segment driver.
// Score events are level changes on score_signal; digit scan advances on rising edges of sclk.
module seven_seg_display (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic [3:0] get_score,
  input  logic       game_end,
  input  logic       score_signal,
  output logic [3:0] selected,
  output logic [6:0] seg
);

  logic [3:0] dig_q [4];
  logic [3:0] dig_d [4];
  logic       ss_q;
  logic       sclk_q;
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic [3:0] selected_q;
  logic [6:0] seg_q;

  logic       score_ev;
  logic [3:0] add_u;
  logic       add_t;
  logic [3:0] addend;
  logic [4:0] sum;
  logic [4:0] sum_wrap;
  logic       carry;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = 7'b1111111;
    endcase
  endfunction

  assign score_ev = (score_signal != ss_q) && !game_end;

  // get_score is split into a tens bit and a units digit, then added with decimal ripple carry.
  always_comb begin
    add_t    = (get_score >= 4'd10);
    add_u    = add_t ? (get_score - 4'd10) : get_score;
    carry    = 1'b0;
    addend   = '0;
    sum      = '0;
    sum_wrap = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
    end
    if (score_ev) begin
      for (int unsigned i = 0; i < 4; i++) begin
        case (i)
          0:       addend = add_u;
          1:       addend = {3'b000, add_t};
          default: addend = '0;
        endcase
        sum      = {1'b0, dig_q[i]} + {1'b0, addend} + {4'b0000, carry};
        sum_wrap = sum - 5'd10;
        if (sum > 5'd9) begin
          dig_d[i] = sum_wrap[3:0];
          carry    = 1'b1;
        end else begin
          dig_d[i] = sum[3:0];
          carry    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (sclk && !sclk_q) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    ss_q   <= score_signal;
    sclk_q <= sclk;
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        dig_q[i] <= '0;
      end
      idx_q      <= '0;
      selected_q <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
      end
      idx_q      <= idx_d;
      selected_q <= ~(4'b0001 << idx_q);
      seg_q      <= seg_pattern(dig_q[idx_q]);
    end
  end

  assign selected = selected_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Bench for seven_seg_display: decimal-integer score model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seven_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic [3:0] get_score = '0;
  logic       game_end = 1'b0;
  logic       score_signal = 1'b0;
  logic [3:0] selected;
  logic [6:0] seg;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  seven_seg_display dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .get_score    (get_score),
    .game_end     (game_end),
    .score_signal (score_signal),
    .selected     (selected),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  // Reference model: score as a plain integer modulo 10000, scan index as an integer.
  int         m_score;
  int         m_idx;
  logic       m_ss;
  logic       m_sclk;
  logic [3:0] exp_sel;
  logic [6:0] exp_seg;

  function automatic int digit_of(input int score, input int idx);
    int div;
    div = 1;
    for (int k = 0; k < idx; k++) div = div * 10;
    return (score / div) % 10;
  endfunction

  always @(posedge clk) begin
    m_ss   <= score_signal;
    m_sclk <= sclk;
    if (rst) begin
      m_score <= 0;
      m_idx   <= 0;
      exp_sel <= 4'b1110;
      exp_seg <= SEG_TBL[0];
    end else begin
      if (score_signal != m_ss && !game_end)
        m_score <= (m_score + int'(get_score)) % 10000;
      if (sclk && !m_sclk)
        m_idx <= (m_idx + 1) % 4;
      exp_sel <= ~(4'b0001 << m_idx);
      exp_seg <= SEG_TBL[digit_of(m_score, m_idx)];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (selected !== exp_sel || seg !== exp_seg) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: selected=%b seg=%b, expected selected=%b seg=%b",
                 $time, selected, seg, exp_sel, exp_seg);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  task automatic add(input int n);
    get_score    = n[3:0];
    score_signal = ~score_signal;
    cyc(1);
  endtask

  task automatic set_score(input int v);
    int rem;
    do_reset(1);
    rem = v;
    while (rem >= 15) begin
      add(15);
      rem -= 15;
    end
    if (rem > 0) add(rem);
    cyc(2);
  endtask

  localparam logic [3:0] SEL_SEQ [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  localparam logic [6:0] SEG_SEQ [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};

  initial begin
    // Reset with score_signal held high: no event after release.
    score_signal = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(3);
    check("reset_selected", int'(selected), 32'b1110);
    check("reset_seg", int'(seg), 32'b1000000);
    check("reset_no_spurious", m_score, 0);

    // Accumulate four 1-point events, two cycles apart.
    get_score = 4'd1;
    for (int i = 0; i < 4; i++) begin
      score_signal = ~score_signal;
      cyc(2);
    end
    cyc(1);
    check("accum_score", m_score, 4);
    check("accum_seg_d0", int'(seg), 32'b0011001);

    set_score(9);  add(1);  cyc(2);
    check("carry_9p1", m_score, 10);
    check("carry_9p1_seg", int'(seg), 32'b1000000);
    set_score(0);  add(15); cyc(2);
    check("add15", m_score, 15);
    check("add15_seg", int'(seg), 32'b0010010);
    set_score(995); add(7); cyc(2);
    check("carry_995p7", m_score, 1002);
    check("carry_995p7_seg", int'(seg), 32'b0100100);
    set_score(9998); add(5); cyc(2);
    check("wrap_9998p5", m_score, 3);
    check("wrap_seg", int'(seg), 32'b0110000);

    // Freeze while game_end is high, then resume.
    game_end = 1'b1;
    for (int i = 0; i < 3; i++) begin
      add(5);
      cyc(1);
    end
    game_end = 1'b0;
    cyc(2);
    check("freeze_score", m_score, 3);
    check("freeze_seg", int'(seg), 32'b0110000);
    add(5); cyc(2);
    check("resume_score", m_score, 8);
    check("resume_seg", int'(seg), 32'b0000000);

    // Scan through 1234 with multi-cycle sclk pulses.
    set_score(1234);
    check("scan_start_sel", int'(selected), 32'b1110);
    check("scan_start_seg", int'(seg), 32'b0011001);
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1;
      cyc(3);
      check($sformatf("scan_sel_%0d", k), int'(selected), int'(SEL_SEQ[k]));
      check($sformatf("scan_seg_%0d", k), int'(seg), int'(SEG_SEQ[k]));
      sclk = 1'b0;
      cyc(3);
    end

    // Reset coinciding with a score event and an sclk rise.
    set_score(42);
    check("pre_midreset_score", m_score, 42);
    rst          = 1'b1;
    get_score    = 4'd5;
    score_signal = ~score_signal;
    sclk         = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("midreset_score", m_score, 0);
    check("midreset_sel", int'(selected), 32'b1110);
    check("midreset_seg", int'(seg), 32'b1000000);
    sclk = 1'b0;
    cyc(2);

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 4000; i++) begin
      get_score = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) score_signal = ~score_signal;
      if ($urandom_range(0, 9) == 0) game_end = ~game_end;
      if ($urandom_range(0, 3) == 0) sclk = ~sclk;
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_display.md
# seven_seg_display

Score accumulator and 4-digit multiplexed seven-segment driver for the game top level. Each toggle of `score_signal` adds the 4-bit `get_score` value to a 4-digit BCD score, unless the game has ended. The score is shown on a common-anode display, one digit at a time, with the active digit advanced by rising edges of the slow scan strobe `sclk`.

## Interface
- No parameters.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sclk` input 1: slow scan strobe, sampled on `clk` (not a clock); each rising edge advances the displayed digit.
- `get_score` input 4: points to add per score event, 0–15.
- `game_end` input 1: level; while high, score events are ignored and the score is frozen.
- `score_signal` input 1: score event line; every level change (either direction) is one event.
- `selected` output 4: digit enables, active-low, exactly one bit low; bit 0 = units, bit 3 = thousands.
- `seg` output 7: segments, active-low, `seg[0]`=a … `seg[6]`=g.

## Operation
- State held:
  - Score: four BCD digits d3..d0.
  - `ss_q`: previous sample of `score_signal`.
  - `sclk_q`: previous sample of `sclk`.
  - `idx`: 2-bit scan index.
  - Registered outputs.
- Score event: `score_signal != ss_q`. Event and `game_end`=0 → score ← score + `get_score`. Event and `game_end`=1 → event dropped.
- BCD add:
  - Split `get_score` into tens t (0/1) and units u (`get_score`−10t).
  - Add u to d0 and t to d1, with decimal carry propagating d0→d1→d2→d3.
  - 9999 + n wraps modulo 10000; e.g. 9998 + 5 = 0003.
- `ss_q` ← `score_signal` every cycle, including during reset. A reset never produces a spurious event afterwards.
- Scan:
  - `sclk`=1 and `sclk_q`=0 → `idx` ← `idx`+1 (3 wraps to 0).
  - `sclk_q` ← `sclk` every cycle.
- Output decode, registered from current `idx` and score:
  - `selected` = ~(1 << `idx`).
  - `seg` = pattern of digit d[`idx`].
  - Leading zeros are displayed, not blanked.
- Segment patterns (`seg[6:0]`, gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- `game_end` does not affect scanning or display.

## Timing
- Reset (sampled high at a `clk` edge):
  - Score=0000, `idx`=0.
  - `selected`=4'b1110, `seg`=7'b1000000.
  - `ss_q`←`score_signal`, `sclk_q`←`sclk`.
  - Reset has priority over score events and scan edges in the same cycle.
- Score latency: `score_signal` changes before edge N → score register updated at edge N. Displayed value reflects it at edge N+1, provided that digit is selected.
- Scan latency: `sclk` rises before edge N → `idx` updates at edge N; `selected`/`seg` update at edge N+1.
- One event per `clk` cycle maximum. Toggles faster than `clk` may be lost; no requirement to count them.
- `get_score` and `game_end` are sampled at the same edge that detects the event.
- Scan edge and score event in the same cycle: both take effect independently.

## Test plan
- Reset: `rst`=1 for 5 cycles, `score_signal`=0 → `selected`=1110, `seg`=1000000. No score change after release, even if `score_signal`=1 throughout reset.
- Accumulate: `get_score`=1; toggle `score_signal` 4 times, ≥2 `clk` cycles apart → score 0004. Digit 0 shows `seg`=0011001.
- Carry/large add: from 0009 add 1 → 0010. From 0000 add 15 → 0015. From 0995 add 7 → 1002. From 9998 add 5 → 0003.
- Freeze: `game_end`=1, toggle `score_signal` 3 times with `get_score`=5 → score unchanged. Drop `game_end`, toggle once → +5.
- Scan: score 1234; pulse `sclk` high 3 `clk` cycles, low 3, repeatedly.
  - `selected` sequence: 1110, 1101, 1011, 0111, 1110.
  - `seg` sequence: 0011001, 0110000, 0100100, 1111001.
  - `idx` advances exactly once per `sclk` rise, not per `clk` while high.
- Mid-operation reset: score 0042, assert `rst` in the same cycle as a `score_signal` toggle and an `sclk` rise → score 0000, `selected`=1110, `seg`=1000000.
